// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and note/velocity types
// used by the byte parser and the voice allocator.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [7:0] SYSTEM_MIN   = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parse_state_e;

  typedef logic [6:0] note_t;
  typedef logic [6:0] vel_t;

endpackage

// File: rtl/midi_voice_alloc_if.sv
// Received-byte bus from the MIDI UART: one byte plus a single-cycle valid strobe.
interface midi_voice_alloc_if;

  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (output rx_byte, output rx_valid);
  modport slave  (input  rx_byte, input  rx_valid);

endinterface

// File: rtl/midi_byte_parser.sv
// MIDI note-message parser with running status. Define MIDI_OMNI_EN to accept
// note messages on all 16 channels instead of only CHANNEL.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  midi_voice_alloc_if.slave   rx,
  output logic                ev_valid_o,
  output note_t               ev_note_o,
  output vel_t                ev_vel_o,
  output logic                ev_on_o
);

  parse_state_e state_q;
  note_t        note_q;
  logic         run_on_q;
  logic         chan_ok;
  logic         is_note_status;

`ifdef MIDI_OMNI_EN
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (rx.rx_byte[3:0] == 4'(CHANNEL));
`endif

  assign is_note_status = ((rx.rx_byte[7:4] == NOTE_OFF) || (rx.rx_byte[7:4] == NOTE_ON)) && chan_ok;

  // Realtime bytes fall through untouched so they can be interleaved anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      note_q   <= '0;
      run_on_q <= 1'b0;
    end else if (rx.rx_valid && (rx.rx_byte < REALTIME_MIN)) begin
      if (rx.rx_byte >= SYSTEM_MIN) begin
        state_q <= IDLE;
      end else if (rx.rx_byte[7]) begin
        if (is_note_status) begin
          state_q  <= WAIT_D1;
          run_on_q <= (rx.rx_byte[7:4] == NOTE_ON);
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            note_q  <= rx.rx_byte[6:0];
            state_q <= WAIT_D2;
          end
          WAIT_D2: state_q <= WAIT_D1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The event is decoded from the velocity byte itself so the allocator can act on the same edge.
  assign ev_valid_o = rx.rx_valid && !rx.rx_byte[7] && (state_q == WAIT_D2);
  assign ev_note_o  = note_q;
  assign ev_vel_o   = rx.rx_byte[6:0];
  assign ev_on_o    = run_on_q && (rx.rx_byte[6:0] != 7'd0);

endmodule

// File: rtl/midi_voice_alloc.sv
// Voice allocator: retrigger held note, else lowest free voice, else round-robin
// steal; drives per-voice note, velocity, gate and trigger strobes.
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int unsigned NUMVOICES = 4,
  parameter int unsigned CHANNEL   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  midi_voice_alloc_if.slave    rx,
  output note_t                midi_notenums [0:NUMVOICES-1],
  output vel_t                 velocities    [0:NUMVOICES-1],
  output logic [NUMVOICES-1:0] gates,
  output logic [NUMVOICES-1:0] voice_trig
);

  localparam int unsigned IDXW = $clog2(NUMVOICES);
  typedef logic [IDXW-1:0] idx_t;

  logic  ev_valid;
  note_t ev_note;
  vel_t  ev_vel;
  logic  ev_on;

  midi_byte_parser #(.CHANNEL(CHANNEL)) u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .ev_valid_o (ev_valid),
    .ev_note_o  (ev_note),
    .ev_vel_o   (ev_vel),
    .ev_on_o    (ev_on)
  );

  note_t                notenum_q [0:NUMVOICES-1];
  note_t                notenum_d [0:NUMVOICES-1];
  vel_t                 vel_q     [0:NUMVOICES-1];
  vel_t                 vel_d     [0:NUMVOICES-1];
  logic [NUMVOICES-1:0] gate_q, gate_d;
  logic [NUMVOICES-1:0] trig_q, trig_d;
  idx_t                 steal_q, steal_d;

  logic match_hit, free_hit;
  idx_t match_idx, free_idx, sel_idx;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int v = 0; v < NUMVOICES; v++) begin
      if (!match_hit && gate_q[v] && (notenum_q[v] == ev_note)) begin
        match_hit = 1'b1;
        match_idx = idx_t'(v);
      end
      if (!free_hit && !gate_q[v]) begin
        free_hit = 1'b1;
        free_idx = idx_t'(v);
      end
    end
  end

  // Steal pointer moves only when every voice is busy with a different note.
  always_comb begin
    notenum_d = notenum_q;
    vel_d     = vel_q;
    gate_d    = gate_q;
    trig_d    = '0;
    steal_d   = steal_q;
    sel_idx   = steal_q;
    if (ev_valid) begin
      if (ev_on) begin
        if (match_hit) begin
          sel_idx = match_idx;
        end else if (free_hit) begin
          sel_idx = free_idx;
        end else begin
          steal_d = steal_q + 1'b1;
        end
        notenum_d[sel_idx] = ev_note;
        vel_d[sel_idx]     = ev_vel;
        gate_d[sel_idx]    = 1'b1;
        trig_d[sel_idx]    = 1'b1;
      end else if (match_hit) begin
        gate_d[match_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      notenum_q <= '{default: '0};
      vel_q     <= '{default: '0};
      gate_q    <= '0;
      trig_q    <= '0;
      steal_q   <= '0;
    end else begin
      notenum_q <= notenum_d;
      vel_q     <= vel_d;
      gate_q    <= gate_d;
      trig_q    <= trig_d;
      steal_q   <= steal_d;
    end
  end

  assign midi_notenums = notenum_q;
  assign velocities    = vel_q;
  assign gates         = gate_q;
  assign voice_trig    = trig_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc: directed vector table, hand-written
// steal/reset sequences and random byte streams against a message-level model.
module tb_midi_voice_alloc;

  localparam int NV = 4;
  localparam int CH = 0;
`ifdef MIDI_OMNI_EN
  localparam bit OMNI = 1'b1;
`else
  localparam bit OMNI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    notenums   [0:NV-1];
  logic [6:0]    velocities [0:NV-1];
  logic [NV-1:0] gates;
  logic [NV-1:0] voiceTrig;

  always #5 clk = ~clk;

  midi_voice_alloc_if rxIf ();

  midi_voice_alloc #(.NUMVOICES(NV), .CHANNEL(CH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rxIf),
    .midi_notenums (notenums),
    .velocities    (velocities),
    .gates         (gates),
    .voice_trig    (voiceTrig)
  );

  // Reference model: voices as plain arrays, message assembly as "current status + pending note".
  int            mNote [NV];
  int            mVel  [NV];
  bit            mGate [NV];
  int            mSteal;
  int            mRun;
  int            mPend;
  logic [NV-1:0] mTrig;

  int errCount   = 0;
  int checkCount = 0;

  function automatic void modelReset();
    for (int v = 0; v < NV; v++) begin
      mNote[v] = 0;
      mVel[v]  = 0;
      mGate[v] = 1'b0;
    end
    mSteal = 0;
    mRun   = -1;
    mPend  = -1;
    mTrig  = '0;
  endfunction

  function automatic void modelEvent(input int note, input int vel, input bit isOn);
    int idx;
    idx = -1;
    for (int v = 0; v < NV; v++)
      if (idx < 0 && mGate[v] && mNote[v] == note) idx = v;
    if (isOn) begin
      if (idx < 0)
        for (int v = 0; v < NV; v++)
          if (idx < 0 && !mGate[v]) idx = v;
      if (idx < 0) begin
        idx    = mSteal;
        mSteal = (mSteal + 1) % NV;
      end
      mNote[idx] = note;
      mVel[idx]  = vel;
      mGate[idx] = 1'b1;
      mTrig[idx] = 1'b1;
    end else if (idx >= 0) begin
      mGate[idx] = 1'b0;
    end
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    int bi;
    bit accept;
    bi    = int'(b);
    mTrig = '0;
    if (bi >= 248) return;
    if (bi >= 240) begin
      mRun  = -1;
      mPend = -1;
      return;
    end
    if (bi >= 128) begin
      accept = ((bi / 16) == 8 || (bi / 16) == 9) && (OMNI || (bi % 16) == CH);
      mRun   = accept ? bi : -1;
      mPend  = -1;
      return;
    end
    if (mRun < 0) return;
    if (mPend < 0) begin
      mPend = bi;
      return;
    end
    modelEvent(mPend, bi, (mRun / 16) == 9 && bi != 0);
    mPend = -1;
  endfunction

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NV-1:0] expGates;
    for (int v = 0; v < NV; v++) expGates[v] = mGate[v];
    compareValue({tag, " gates"}, 32'(gates), 32'(expGates));
    compareValue({tag, " voice_trig"}, 32'(voiceTrig), 32'(mTrig));
    for (int v = 0; v < NV; v++) begin
      compareValue($sformatf("%s note[%0d]", tag, v), 32'(notenums[v]), 32'(mNote[v]));
      compareValue($sformatf("%s vel[%0d]", tag, v), 32'(velocities[v]), 32'(mVel[v]));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input string tag);
    @(negedge clk);
    rxIf.rx_byte  = b;
    rxIf.rx_valid = 1'b1;
    @(posedge clk);
    modelByte(b);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    rxIf.rx_valid = 1'b0;
    rxIf.rx_byte  = 8'h00;
    @(posedge clk);
    mTrig = '0;
    #1;
    checkOutput(tag);
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    rxIf.rx_valid = 1'b0;
    rst_n         = 1'b0;
    #2;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic [3:0] expGates;
    logic [3:0] expTrig;
    logic [6:0] expNote0;
    logic [6:0] expNote1;
    logic [6:0] expVel0;
  } vec_t;

  vec_t vecs [17];

  initial begin
    rst_n         = 1'b0;
    rxIf.rx_byte  = 8'h00;
    rxIf.rx_valid = 1'b0;
    modelReset();

    vecs[0]  = '{8'h90, 4'b0000, 4'b0000, 7'd0,  7'd0,  7'd0};
    vecs[1]  = '{8'h3C, 4'b0000, 4'b0000, 7'd0,  7'd0,  7'd0};
    vecs[2]  = '{8'h64, 4'b0001, 4'b0001, 7'd60, 7'd0,  7'd100};
    vecs[3]  = '{8'h40, 4'b0001, 4'b0000, 7'd60, 7'd0,  7'd100};
    vecs[4]  = '{8'h50, 4'b0011, 4'b0010, 7'd60, 7'd64, 7'd100};
    vecs[5]  = '{8'h90, 4'b0011, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[6]  = '{8'h3C, 4'b0011, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[7]  = '{8'h00, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[8]  = '{8'hF8, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[9]  = '{8'h80, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[10] = '{8'hF8, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[11] = '{8'h40, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[12] = '{8'hF8, 4'b0010, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[13] = '{8'h40, 4'b0000, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[14] = '{8'h91, 4'b0000, 4'b0000, 7'd60, 7'd64, 7'd100};
    vecs[15] = '{8'h3C, 4'b0000, 4'b0000, 7'd60, 7'd64, 7'd100};
`ifdef MIDI_OMNI_EN
    vecs[16] = '{8'h64, 4'b0001, 4'b0001, 7'd60, 7'd64, 7'd100};
`else
    vecs[16] = '{8'h64, 4'b0000, 4'b0000, 7'd60, 7'd64, 7'd100};
`endif

    pulseReset("reset");
    compareValue("reset gates zero", 32'(gates), 32'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].b, $sformatf("vec%0d", i));
      compareValue($sformatf("vec%0d tbl gates", i), 32'(gates), 32'(vecs[i].expGates));
      compareValue($sformatf("vec%0d tbl trig", i), 32'(voiceTrig), 32'(vecs[i].expTrig));
      compareValue($sformatf("vec%0d tbl note0", i), 32'(notenums[0]), 32'(vecs[i].expNote0));
      compareValue($sformatf("vec%0d tbl note1", i), 32'(notenums[1]), 32'(vecs[i].expNote1));
      compareValue($sformatf("vec%0d tbl vel0", i), 32'(velocities[0]), 32'(vecs[i].expVel0));
    end
    idleCycle("vec idle");

    // Six note-ons on a full pool: fifth steals voice0, sixth steals voice1.
    pulseReset("steal reset");
    applyStimulus(8'h90, "steal status");
    for (int n = 60; n <= 65; n++) begin
      applyStimulus(8'(n), "steal note");
      applyStimulus(8'd100, "steal vel");
      if (n == 64) begin
        compareValue("steal5 note0", 32'(notenums[0]), 32'd64);
        compareValue("steal5 trig", 32'(voiceTrig), 32'b0001);
        compareValue("steal5 gates", 32'(gates), 32'b1111);
      end
      if (n == 65) begin
        compareValue("steal6 note1", 32'(notenums[1]), 32'd65);
        compareValue("steal6 trig", 32'(voiceTrig), 32'b0010);
        compareValue("steal6 note3", 32'(notenums[3]), 32'd63);
      end
    end
    idleCycle("steal idle");
    compareValue("steal trig one cycle", 32'(voiceTrig), 32'd0);

    // Reset mid-message drops the partial note.
    pulseReset("mid reset0");
    applyStimulus(8'h90, "mid a");
    applyStimulus(8'h3C, "mid b");
    applyStimulus(8'h64, "mid c");
    applyStimulus(8'h90, "mid d");
    applyStimulus(8'h3E, "mid e");
    pulseReset("mid reset");
    compareValue("mid reset gates", 32'(gates), 32'd0);
    compareValue("mid reset note0", 32'(notenums[0]), 32'd0);
    applyStimulus(8'h64, "mid after");
    compareValue("mid after gates", 32'(gates), 32'd0);
    compareValue("mid after trig", 32'(voiceTrig), 32'd0);

    // Random streams, full-rate with occasional gaps and resets.
    pulseReset("rand reset");
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        idleCycle("rand idle");
      end else if (r < 9) begin
        pulseReset("rand reset");
      end else begin
        if (r < 24) begin
          case ($urandom_range(0, 5))
            0: b = 8'h80;
            1: b = 8'h90;
            2: b = 8'h90;
            3: b = 8'h91;
            4: b = 8'hB0;
            default: b = 8'h8F;
          endcase
        end else if (r < 27) begin
          b = 8'hF8;
        end else if (r < 29) begin
          b = 8'hF0;
        end else if (r < 37) begin
          b = 8'h00;
        end else begin
          b = 8'(58 + $urandom_range(0, 7));
        end
        applyStimulus(b, "rand");
      end
    end
    idleCycle("final idle");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
